// File: rtl/eg_pwrmnt_ctrl.sv
// eg_pwrmnt_ctrl -- controller for the Eagle power-monitor primitive (EG_PHY_PWRMNT).
//
// Sequences monitor power-up and settling, synchronizes and debounces the
// primitive's brown-out flag, and reports a qualified power-good level, a
// one-cycle brown-out event and a saturating brown-out count.
//
// Parameters:
//   SETTLE_CYCLES  cycles spent in SETTLE after power-up or a rail change (>=1)
//   FILT_LEN       consecutive identical synchronized samples to move the filter (>=1)
//   CNT_W          width of fault_cnt
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   en          in   monitor enable request
//   sel_req     in   requested rail select
//   clr_fault   in   releases a latched FAULT (only with PWRMNT_FAULT_LATCH_EN)
//   pwr_dwn_n   in   asynchronous brown-out flag from the primitive, 0 = rail low
//   sel_pwr     out  rail select to the primitive
//   pwr_mnt_pd  out  monitor power-down to the primitive, 1 = powered down
//   pwr_ok      out  qualified power good
//   brownout    out  one-cycle pulse on each GOOD->FAULT transition
//   busy        out  high while settling or qualifying
//   fault_cnt   out  saturating count of brown-out events
//
// Build option:
//   PWRMNT_FAULT_LATCH_EN  defined: FAULT is sticky and leaves only on clr_fault
//                          while the filtered level is high.
//                          undefined: FAULT returns to GOOD when the level rises.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OFF     | monitor powered down, sel_pwr tracks sel_req
// SETTLE  | monitor powered, waiting SETTLE_CYCLES, filter held clear
// QUALIFY | waiting for the filtered level to first rise
// GOOD    | rail qualified good, pwr_ok high
// FAULT   | brown-out seen, waiting for recovery

module eg_pwrmnt_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int FILT_LEN      = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sel_req,
   input  logic             clr_fault,
   input  logic             pwr_dwn_n,
   output logic             sel_pwr,
   output logic             pwr_mnt_pd,
   output logic             pwr_ok,
   output logic             brownout,
   output logic             busy,
   output logic [CNT_W-1:0] fault_cnt
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_QUALIFY = 3'd2,
      ST_GOOD    = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   state_t            state, state_n;
   logic              sync1, s;
   logic              f, f_run;
   logic [FC_W-1:0]   fcnt, fcnt_run;
   logic [SC_W-1:0]   settle_cnt;
   logic              sel_pwr_n;
   logic              settle_load;
   logic              filt_clr;
   logic              f_rise, f_fall;
   logic              fault_evt;
   logic              rail_chg;

`ifndef PWRMNT_FAULT_LATCH_EN
   logic unused_clr_fault;
   assign unused_clr_fault = clr_fault;
`endif

   // Free-running filter step; the clear for SETTLE is applied at the register
   // so the FSM can see the would-be edge without a combinational loop.
   always_comb begin
      f_run    = f;
      fcnt_run = '0;
      if (s != f) begin
         if (fcnt == FC_LAST) begin
            f_run    = s;
            fcnt_run = '0;
         end else begin
            fcnt_run = fcnt + 1'b1;
         end
      end
   end

   assign f_rise   = ~f & f_run;
   assign f_fall   = f & ~f_run;
   assign rail_chg = (sel_req != sel_pwr);

   always_comb begin
      state_n     = state;
      sel_pwr_n   = sel_pwr;
      settle_load = 1'b0;
      fault_evt   = 1'b0;
      if (state == ST_OFF) begin
         sel_pwr_n = sel_req;
         if (en) begin
            state_n     = ST_SETTLE;
            settle_load = 1'b1;
         end
      end else if (!en) begin
         state_n = ST_OFF;
      end else if (rail_chg) begin
         // rail change outranks a coincident brown-out: no event is counted
         sel_pwr_n   = sel_req;
         state_n     = ST_SETTLE;
         settle_load = 1'b1;
      end else begin
         case (state)
            ST_SETTLE:  if (settle_cnt == '0) state_n = ST_QUALIFY;
            ST_QUALIFY: if (f_rise) state_n = ST_GOOD;
            ST_GOOD: begin
               if (f_fall) begin
                  state_n   = ST_FAULT;
                  fault_evt = 1'b1;
               end
            end
            ST_FAULT: begin
`ifdef PWRMNT_FAULT_LATCH_EN
               if (f && clr_fault) state_n = ST_GOOD;
`else
               if (f_rise) state_n = ST_GOOD;
`endif
            end
            default: state_n = ST_OFF;
         endcase
      end
   end

   // Filter is held clear for the whole of SETTLE, including the entry edge.
   assign filt_clr = (state == ST_SETTLE) || (state_n == ST_SETTLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_OFF;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1      <= 1'b0;
         s          <= 1'b0;
         f          <= 1'b0;
         fcnt       <= '0;
         settle_cnt <= '0;
         sel_pwr    <= 1'b0;
         pwr_mnt_pd <= 1'b1;
         pwr_ok     <= 1'b0;
         brownout   <= 1'b0;
         busy       <= 1'b0;
         fault_cnt  <= '0;
      end else begin
         sync1 <= pwr_dwn_n;
         s     <= sync1;
         if (filt_clr) begin
            f    <= 1'b0;
            fcnt <= '0;
         end else begin
            f    <= f_run;
            fcnt <= fcnt_run;
         end
         if (settle_load) begin
            settle_cnt <= SC_LOAD;
         end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
         sel_pwr    <= sel_pwr_n;
         pwr_mnt_pd <= (state_n == ST_OFF);
         pwr_ok     <= (state_n == ST_GOOD);
         busy       <= (state_n == ST_SETTLE) || (state_n == ST_QUALIFY);
         brownout   <= fault_evt;
         if (fault_evt && (fault_cnt != '1)) begin
            fault_cnt <= fault_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eg_pwrmnt_ctrl.sv
// tb_eg_pwrmnt_ctrl -- bench for eg_pwrmnt_ctrl with a behavioural reference
// model, directed scenarios and a randomized soak.
module tb_eg_pwrmnt_ctrl;

   localparam int SETTLE_CYCLES = 16;
   localparam int FILT_LEN      = 4;
   localparam int CNT_W         = 8;
   localparam int CNT_MAX       = (1 << CNT_W) - 1;
`ifdef PWRMNT_FAULT_LATCH_EN
   localparam int REC_LAT = 7;
`else
   localparam int REC_LAT = 6;
`endif

   localparam int M_OFF = 0, M_SETTLE = 1, M_QUAL = 2, M_GOOD = 3, M_FAULT = 4;

   logic             clk = 1'b0;
   logic             rst_n, en, sel_req, clr_fault, pwr_dwn_n;
   logic             sel_pwr, pwr_mnt_pd, pwr_ok, brownout, busy;
   logic [CNT_W-1:0] fault_cnt;

   int n_vec = 0;
   int n_err = 0;

   eg_pwrmnt_ctrl #(
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .FILT_LEN     (FILT_LEN),
      .CNT_W        (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sel_req   (sel_req),
      .clr_fault (clr_fault),
      .pwr_dwn_n (pwr_dwn_n),
      .sel_pwr   (sel_pwr),
      .pwr_mnt_pd(pwr_mnt_pd),
      .pwr_ok    (pwr_ok),
      .brownout  (brownout),
      .busy      (busy),
      .fault_cnt (fault_cnt)
   );

   always #5 clk = ~clk;

   // reference model state
   int m_mode    = M_OFF;
   bit hist[$]   = '{1'b0, 1'b0};   // last two sampled pwr_dwn_n values, oldest first
   bit m_f       = 1'b0;
   int m_run     = 0;
   int m_elapsed = 0;
   bit m_sel     = 1'b0;
   int m_cnt     = 0;
   bit m_bo      = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit sr, input bit p, input bit cf);
      bit s_old, f_new, rose, fell;
      int run_new, nxt;
      if (!r) begin
         m_mode = M_OFF; hist = '{1'b0, 1'b0}; m_f = 1'b0; m_run = 0;
         m_elapsed = 0; m_sel = 1'b0; m_cnt = 0; m_bo = 1'b0;
      end else begin
         s_old   = hist[0];
         f_new   = m_f;
         run_new = 0;
         if (s_old != m_f) begin
            run_new = m_run + 1;
            if (run_new == FILT_LEN) begin
               f_new   = s_old;
               run_new = 0;
            end
         end
         rose = !m_f && f_new;
         fell = m_f && !f_new;
         m_bo = 1'b0;
         nxt  = m_mode;
         if (m_mode == M_OFF) begin
            m_sel = sr;
            if (e) begin nxt = M_SETTLE; m_elapsed = 0; end
         end else if (!e) begin
            nxt = M_OFF;
         end else if (sr != m_sel) begin
            m_sel = sr; nxt = M_SETTLE; m_elapsed = 0;
         end else if (m_mode == M_SETTLE) begin
            m_elapsed++;
            if (m_elapsed == SETTLE_CYCLES) nxt = M_QUAL;
         end else if (m_mode == M_QUAL) begin
            if (rose) nxt = M_GOOD;
         end else if (m_mode == M_GOOD) begin
            if (fell) begin
               nxt = M_FAULT; m_bo = 1'b1;
               if (m_cnt < CNT_MAX) m_cnt++;
            end
         end else begin
`ifdef PWRMNT_FAULT_LATCH_EN
            if (m_f && cf) nxt = M_GOOD;
`else
            if (rose) nxt = M_GOOD;
`endif
         end
         if (m_mode == M_SETTLE || nxt == M_SETTLE) begin
            m_f = 1'b0; m_run = 0;
         end else begin
            m_f = f_new; m_run = run_new;
         end
         m_mode = nxt;
         void'(hist.pop_front());
         hist.push_back(p);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst_n, en, sel_req, pwr_dwn_n, clr_fault);
      @(negedge clk);
      chk("sel_pwr",    sel_pwr,    m_sel);
      chk("pwr_mnt_pd", pwr_mnt_pd, m_mode == M_OFF);
      chk("pwr_ok",     pwr_ok,     m_mode == M_GOOD);
      chk("busy",       busy,       m_mode == M_SETTLE || m_mode == M_QUAL);
      chk("brownout",   brownout,   m_bo);
      chk("fault_cnt",  fault_cnt,  m_cnt);
   endtask

   initial begin
      int t_ok, t_bo, bo_n, busy_n, nok_n, run_left;
      bit ok_all;

      rst_n = 1'b0; en = 1'b0; sel_req = 1'b0; clr_fault = 1'b0; pwr_dwn_n = 1'b1;
      repeat (3) tick();
      chk("rst_pd",  pwr_mnt_pd, 1);
      chk("rst_ok",  pwr_ok, 0);
      chk("rst_cnt", fault_cnt, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // power-up latency
      en = 1'b1; t_ok = 0; busy_n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 1) chk("pd_after_en", pwr_mnt_pd, 0);
         if (busy) busy_n++;
         if (pwr_ok && t_ok == 0) t_ok = i;
      end
      chk("ok_latency", t_ok - 1, SETTLE_CYCLES + FILT_LEN);
      chk("busy_len",   busy_n,   SETTLE_CYCLES + FILT_LEN);

      // short glitch rejected
      ok_all = 1'b1; bo_n = 0;
      pwr_dwn_n = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); ok_all &= pwr_ok; bo_n += int'(brownout); end
      pwr_dwn_n = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); ok_all &= pwr_ok; bo_n += int'(brownout); end
      chk("glitch_ok",  ok_all, 1);
      chk("glitch_bo",  bo_n, 0);
      chk("glitch_cnt", fault_cnt, 0);

      // long brown-out and recovery
      pwr_dwn_n = 1'b0; t_bo = 0; bo_n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (brownout) begin bo_n++; if (t_bo == 0) t_bo = i; end
      end
      chk("bo_delay",  t_bo, 6);
      chk("bo_pulses", bo_n, 1);
      chk("cnt_one",   fault_cnt, 1);
      chk("ok_low",    pwr_ok, 0);
      pwr_dwn_n = 1'b1; clr_fault = 1'b1; t_ok = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pwr_ok && t_ok == 0) t_ok = i;
      end
      chk("ok_recover", t_ok, REC_LAT);

      // counter saturation
      bo_n = 0;
      for (int k = 0; k < 260; k++) begin
         pwr_dwn_n = 1'b0;
         repeat (6) begin tick(); bo_n += int'(brownout); end
         pwr_dwn_n = 1'b1;
         repeat (8) begin tick(); bo_n += int'(brownout); end
      end
      chk("bo_events", bo_n, 260);
      chk("sat_cnt",   fault_cnt, CNT_MAX);
      repeat (5) tick();

      // rail change in GOOD
      sel_req = ~sel_req; busy_n = 0; nok_n = 0; bo_n = 0;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 1) chk("sel_follow", sel_pwr, sel_req);
         if (busy) busy_n++;
         if (!pwr_ok) nok_n++;
         bo_n += int'(brownout);
      end
      chk("rail_busy", busy_n, SETTLE_CYCLES + FILT_LEN);
      chk("rail_nok",  nok_n,  SETTLE_CYCLES + FILT_LEN);
      chk("rail_bo",   bo_n, 0);

      // enable dropped during SETTLE
      sel_req = ~sel_req;
      repeat (5) tick();
      en = 1'b0;
      tick();
      chk("endrop_pd",   pwr_mnt_pd, 1);
      chk("endrop_ok",   pwr_ok, 0);
      chk("endrop_busy", busy, 0);
      en = 1'b1;
      repeat (25) tick();

      // randomized soak
      run_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run_left == 0) begin
            pwr_dwn_n = ~pwr_dwn_n;
            run_left  = int'($urandom_range(1, 12));
         end
         run_left--;
         en        = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 149) == 0) sel_req = ~sel_req;
         rst_n     = ($urandom_range(0, 999) >= 3);
         clr_fault = 1'($urandom_range(0, 1));
         tick();
      end

      // reset asserted in FAULT
      rst_n = 1'b1; en = 1'b1; clr_fault = 1'b1; pwr_dwn_n = 1'b1;
      repeat (30) tick();
      pwr_dwn_n = 1'b0;
      repeat (10) tick();
      chk("pre_rst_ok", pwr_ok, 0);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_pd",  pwr_mnt_pd, 1);
      chk("rst_mid_ok",  pwr_ok, 0);
      chk("rst_mid_cnt", fault_cnt, 0);
      rst_n = 1'b1;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eg_pwrmnt_ctrl.md
# eg_pwrmnt_ctrl

Controller for the Eagle power-monitor primitive. It drives the monitor's rail-select (`sel_pwr`) and power-down (`pwr_mnt_pd`) inputs, and consumes and qualifies its `pwr_dwn_n` output. It sequences monitor enable and settling, debounces the brown-out indication, and reports a qualified power-good flag, a one-cycle brown-out event and a saturating fault count. It sits between system control logic and the `EG_PHY_PWRMNT` instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: cycles spent in SETTLE after monitor power-up or a rail change; ≥1.
- `FILT_LEN`, 4: consecutive identical synchronized samples required to change the qualified level; ≥1.
- `CNT_W`, 8: width of `fault_cnt`.

Ports (`clk` is the only clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  1  monitor enable request.
- `sel_req`  in  1  requested rail select.
- `clr_fault`  in  1  clears a latched fault (used only with the configuration macro defined).
- `pwr_dwn_n`  in  1  asynchronous brown-out flag from the primitive; 0 = rail low.
- `sel_pwr`  out  1  rail select to the primitive.
- `pwr_mnt_pd`  out  1  monitor power-down to the primitive; 1 = powered down.
- `pwr_ok`  out  1  qualified power good.
- `brownout`  out  1  one-cycle pulse on each GOOD→FAULT transition.
- `busy`  out  1  high in SETTLE and QUALIFY.
- `fault_cnt`  out  CNT_W  saturating count of brown-out events.

## Operation
- `pwr_dwn_n` passes through a 2-flop synchronizer that runs in all states. The synchronized value is `s`.
- Filter: `fcnt` counts consecutive cycles in which `s` differs from the filtered level `f`. When `fcnt` reaches FILT_LEN, `f` flips to `s` and `fcnt` returns to 0. Any cycle with `s == f` zeroes `fcnt`. `f` is forced to 0 and `fcnt` to 0 whenever SETTLE is entered.
- States:
  - OFF: `pwr_mnt_pd`=1; `sel_pwr` follows `sel_req` each cycle. `en`=1 → SETTLE.
  - SETTLE: `pwr_mnt_pd`=0; down-counter loaded with SETTLE_CYCLES-1. At 0 → QUALIFY.
  - QUALIFY: `f` rising → GOOD. No brownout pulse and no count while in QUALIFY.
  - GOOD: `pwr_ok`=1. `f` falling → FAULT, `brownout`=1 for one cycle, `fault_cnt`+1 (saturates at all-ones).
  - FAULT: `pwr_ok`=0. `f` rising → GOOD.
- `en`=0 in any non-OFF state → OFF on the next edge. This has highest priority.
- `sel_req` != `sel_pwr` in SETTLE/QUALIFY/GOOD/FAULT (with `en`=1) → update `sel_pwr` and re-enter SETTLE, restarting the counter and the filter. A rail change out of GOOD produces no brownout pulse. A rail change in the same cycle as the `f` falling edge in GOOD: the rail change wins and no event is counted.
- `clr_fault` has no effect without the macro.

## Timing
- Reset values: state OFF, `sel_pwr`=0, `pwr_mnt_pd`=1, `pwr_ok`=0, `brownout`=0, `busy`=0, `fault_cnt`=0, synchronizer flops=0, `fcnt`=0, `f`=0.
- All outputs are registered.
- `en` sampled high at edge k → `pwr_mnt_pd`=0 and `busy`=1 from after edge k. SETTLE occupies exactly SETTLE_CYCLES cycles.
- Input-to-filter latency: a level change on `pwr_dwn_n` appears on `s` 2 edges later. `f` flips FILT_LEN edges after that. `pwr_ok` and `brownout` update on the same edge as the `f` change.
- With `pwr_dwn_n` held 1, `pwr_ok` rises FILT_LEN cycles after entering QUALIFY.
- A glitch shorter than FILT_LEN cycles (after synchronization) causes no state change.
- Reset asserted mid-operation returns all outputs to reset values on the next edge. The `fault_cnt` value is lost.

## Configuration
- `PWRMNT_FAULT_LATCH_EN`
- Defined: FAULT is sticky. The FAULT→GOOD transition additionally requires `clr_fault`=1 in a cycle where `f`=1. `clr_fault` while `f`=0 is ignored, and the state stays in FAULT.
- Undefined: FAULT returns to GOOD automatically when `f` rises; `clr_fault` is ignored.

## Test plan
With SETTLE_CYCLES=16, FILT_LEN=4, CNT_W=8:
- Reset, then `en`=1 with `pwr_dwn_n`=1: `pwr_mnt_pd` falls 1 cycle after `en`; `busy`=1 for 20 cycles; `pwr_ok` rises 20 cycles after `en` is sampled.
- In GOOD, a 3-cycle low pulse on `pwr_dwn_n`: `pwr_ok` stays 1, `brownout` stays 0, `fault_cnt`=0.
- In GOOD, a 10-cycle low: `brownout` pulses once 6 cycles after the falling edge; `fault_cnt`=1; `pwr_ok` returns 6 cycles after `pwr_dwn_n` recovers. With the macro defined, `pwr_ok` instead stays 0 until `clr_fault`.
- 260 brown-out events: `fault_cnt` saturates at 255.
- Toggle `sel_req` in GOOD: `sel_pwr` follows next cycle; `pwr_ok`=0 and `busy`=1 for 20 cycles; no `brownout` pulse.
- Drop `en` during SETTLE, and separately assert `rst_n`=0 during FAULT: next cycle OFF, `pwr_mnt_pd`=1, `pwr_ok`=0. After the reset case, `fault_cnt`=0.
